sipo_rx_param: RTL and testbench

//  Parametrised serial-in/parallel-out receiver. Next generation of the fixed 7-bit dice-roller SIPO.

---
 rtl/sipo_rx_param_pkg.sv | 18 +
 rtl/sipo_rx_param_bit_timer.sv | 37 +++
 rtl/sipo_rx_param.sv | 147 ++++++++++++++
 tb/tb_sipo_rx_param.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sipo_rx_param_pkg.sv
// Shared types and counter-width helpers for the parametrised SIPO receiver.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    SHIFT = 2'd2
  } state_t;

  function automatic int cyc_cnt_w(input int cycles_per_bit);
    return (cycles_per_bit < 2) ? 1 : $clog2(cycles_per_bit);
  endfunction

  function automatic int bit_cnt_w(input int data_w);
    return (data_w < 1) ? 1 : $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/sipo_rx_param_bit_timer.sv
// Bit-period timer: counts down to a one-cycle sample strobe, then reloads a full period.
module sipo_bit_timer
  import sipo_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load_half,
  input  logic i_run,
  output logic o_strobe
);

  localparam int CW = cyc_cnt_w(CYCLES_PER_BIT);
  localparam logic [CW-1:0] HALF_M1   = CW'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] PERIOD_M1 = CW'(CYCLES_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  assign o_strobe = i_run && (r_cnt == '0);

  // Loading HALF-1 on the start edge puts the first strobe HALF edges later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load_half) begin
      r_cnt <= HALF_M1;
    end else if (o_strobe) begin
      r_cnt <= PERIOD_M1;
    end else if (i_run) begin
      r_cnt <= r_cnt - CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/sipo_rx_param.sv
// Parametrised serial-in/parallel-out receiver with mid-bit sampling,
// a one-word valid/ready output buffer and a sticky overrun flag.
module sipo_rx_param
  import sipo_pkg::*;
#(
  parameter int DATA_W         = 7,
  parameter int CYCLES_PER_BIT = 10,
  parameter int LSB_FIRST      = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_data_in,
  input  logic              i_start,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_overrun
);

  localparam int BW = bit_cnt_w(DATA_W);

  if (DATA_W < 1) begin : g_bad_data_w
    $error("sipo_rx_param: DATA_W must be >= 1");
  end
  if (CYCLES_PER_BIT < 2) begin : g_bad_cpb
    $error("sipo_rx_param: CYCLES_PER_BIT must be >= 2");
  end
  if ((LSB_FIRST != 0) && (LSB_FIRST != 1)) begin : g_bad_order
    $error("sipo_rx_param: LSB_FIRST must be 0 or 1");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] r_data;
  logic              r_done;
  logic              r_valid;
  logic              r_overrun;
  logic              r_busy;
  logic              w_strobe;
  logic              w_load_half;
  logic              w_run;
  logic              w_last;

  assign w_run       = (r_state != IDLE);
  assign w_load_half = (r_state == IDLE) && i_start;
  assign w_last      = w_strobe && (r_bit_cnt == BW'(DATA_W - 1));

  sipo_bit_timer #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load_half(w_load_half),
    .i_run      (w_run),
    .o_strobe   (w_strobe)
  );

  // Next-state logic; the first sample is taken on the strobe that ends ALIGN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_nxt = ALIGN;
        else         w_state_nxt = IDLE;
      end
      ALIGN: begin
        if (w_last)        w_state_nxt = IDLE;
        else if (w_strobe) w_state_nxt = SHIFT;
        else               w_state_nxt = ALIGN;
      end
      SHIFT: begin
        if (w_last) w_state_nxt = IDLE;
        else        w_state_nxt = SHIFT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Place the current sample directly at its final bit position.
  always_comb begin
    w_shift_nxt = r_shift;
    for (int i = 0; i < DATA_W; i++) begin
      if (w_strobe && (int'(r_bit_cnt) == ((LSB_FIRST != 0) ? i : (DATA_W - 1 - i)))) begin
        w_shift_nxt[i] = i_data_in;
      end else begin
        w_shift_nxt[i] = r_shift[i];
      end
    end
  end

  // Frame state, bit counter, shift register and completion pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_done    <= 1'b0;
      r_word    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      if (w_load_half) begin
        r_bit_cnt <= '0;
      end else if (w_strobe && (r_bit_cnt != BW'(DATA_W))) begin
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end else begin
        r_bit_cnt <= r_bit_cnt;
      end
      r_shift <= w_shift_nxt;
      r_done  <= w_last;
      if (w_last) r_word <= w_shift_nxt;
      else        r_word <= r_word;
    end
  end

  // Output buffer: a completed word loads unless an unconsumed word is stuck.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (r_done) begin
      if (!r_valid || i_ready) begin
        r_data  <= r_word;
        r_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_data_out = r_data;
  assign o_valid    = r_valid;
  assign o_busy     = r_busy;
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_sipo_rx_param.sv
// Randomised and directed bench for sipo_rx_param against a timing-arithmetic reference model.
module tb_sipo_rx_param;

  logic clk;
  logic ab_rstn, ab_start, ab_din, ab_rdy;
  logic c_rstn, c_start, c_din, c_rdy;
  logic [6:0]  a_data, b_data;
  logic [11:0] c_data;
  logic a_valid, a_busy, a_ovr;
  logic b_valid, b_busy, b_ovr;
  logic c_valid, c_busy, c_ovr;

  int n_vec = 0;
  int n_err = 0;
  int t = 0;

  int dw   [3] = '{7, 7, 12};
  int cpb  [3] = '{10, 10, 3};
  int lsbf [3] = '{1, 0, 1};

  bit          m_act     [3];
  int          m_t0      [3];
  int          m_done_at [3];
  logic [11:0] m_acc     [3];
  logic [11:0] m_word    [3];
  logic [11:0] m_data    [3];
  bit          m_valid   [3];
  bit          m_ovr     [3];

  sipo_rx_param #(.DATA_W(7), .CYCLES_PER_BIT(10), .LSB_FIRST(1)) u_a (
    .clk(clk), .reset_n(ab_rstn), .i_data_in(ab_din), .i_start(ab_start), .i_ready(ab_rdy),
    .o_data_out(a_data), .o_valid(a_valid), .o_busy(a_busy), .o_overrun(a_ovr));

  sipo_rx_param #(.DATA_W(7), .CYCLES_PER_BIT(10), .LSB_FIRST(0)) u_b (
    .clk(clk), .reset_n(ab_rstn), .i_data_in(ab_din), .i_start(ab_start), .i_ready(ab_rdy),
    .o_data_out(b_data), .o_valid(b_valid), .o_busy(b_busy), .o_overrun(b_ovr));

  sipo_rx_param #(.DATA_W(12), .CYCLES_PER_BIT(3), .LSB_FIRST(1)) u_c (
    .clk(clk), .reset_n(c_rstn), .i_data_in(c_din), .i_start(c_start), .i_ready(c_rdy),
    .o_data_out(c_data), .o_valid(c_valid), .o_busy(c_busy), .o_overrun(c_ovr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, t, obs, exp);
    end
  endtask

  // Reference: sample k of a frame started at edge t0 is taken at t0+HALF+k*CPB.
  task automatic model_step(input int k, input logic rstn, input logic start,
                            input logic din, input logic rdy);
    int half, off, s;
    if (!rstn) begin
      m_act[k] = 0; m_done_at[k] = -1; m_acc[k] = 12'd0; m_word[k] = 12'd0;
      m_data[k] = 12'd0; m_valid[k] = 0; m_ovr[k] = 0;
      return;
    end
    half = cpb[k] / 2;
    if (m_done_at[k] == t) begin
      if (!m_valid[k] || rdy) begin
        m_data[k] = m_word[k];
        m_valid[k] = 1;
      end else begin
        m_ovr[k] = 1;
      end
    end else if (m_valid[k] && rdy) begin
      m_valid[k] = 0;
    end
    if (m_act[k]) begin
      off = t - m_t0[k];
      if (off >= half && ((off - half) % cpb[k]) == 0) begin
        s = (off - half) / cpb[k];
        m_acc[k][(lsbf[k] != 0) ? s : (dw[k] - 1 - s)] = din;
        if (s == dw[k] - 1) begin
          m_act[k] = 0;
          m_word[k] = m_acc[k];
          m_done_at[k] = t + 1;
        end
      end
    end else if (start) begin
      m_act[k] = 1;
      m_t0[k] = t;
      m_acc[k] = 12'd0;
    end
  endtask

  task automatic check_all();
    logic [11:0] od [3];
    logic ov [3], ob [3], oo [3];
    od[0] = {5'd0, a_data}; ov[0] = a_valid; ob[0] = a_busy; oo[0] = a_ovr;
    od[1] = {5'd0, b_data}; ov[1] = b_valid; ob[1] = b_busy; oo[1] = b_ovr;
    od[2] = c_data;         ov[2] = c_valid; ob[2] = c_busy; oo[2] = c_ovr;
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("data%0d", k), od[k], m_data[k]);
      check_val($sformatf("valid%0d", k), {11'd0, ov[k]}, {11'd0, m_valid[k]});
      check_val($sformatf("busy%0d", k), {11'd0, ob[k]}, {11'd0, m_act[k]});
      check_val($sformatf("overrun%0d", k), {11'd0, oo[k]}, {11'd0, m_ovr[k]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    t++;
    model_step(0, ab_rstn, ab_start, ab_din, ab_rdy);
    model_step(1, ab_rstn, ab_start, ab_din, ab_rdy);
    model_step(2, c_rstn, c_start, c_din, c_rdy);
    #1;
    check_all();
  endtask

  // One default-config frame: edge 0 pulses start (if asked), bit k driven across its period.
  task automatic run_ab(input logic [6:0] p, input bit do_start, input int n, input int rdy_on,
                        input bit rdy_def, input int st1, input int st2, input int rst_e);
    int b;
    for (int e = 0; e <= n; e++) begin
      ab_start = (e == 0) ? do_start : ((e == st1) || (e == st2));
      ab_rdy   = (rdy_on >= 0) ? (e == rdy_on) : rdy_def;
      ab_rstn  = (e != rst_e);
      b = (e - 1) / 10;
      ab_din   = (e >= 1 && b < 7) ? p[b] : 1'($urandom_range(1, 0));
      c_start = 1'b0; c_din = 1'($urandom_range(1, 0)); c_rdy = 1'b1; c_rstn = 1'b1;
      tick();
    end
    ab_start = 1'b0;
    ab_rstn  = 1'b1;
  endtask

  initial begin
    logic [11:0] pc;
    int b;
    ab_rstn = 1'b0; ab_start = 1'b0; ab_din = 1'b0; ab_rdy = 1'b0;
    c_rstn = 1'b0; c_start = 1'b0; c_din = 1'b0; c_rdy = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_val("rst_a_valid", {11'd0, a_valid}, 12'd0);
    check_val("rst_c_busy", {11'd0, c_busy}, 12'd0);
    ab_rstn = 1'b1; c_rstn = 1'b1;

    // Basic frame, LSB and MSB first.
    run_ab(7'b1001101, 1'b1, 66, -1, 1'b1, -1, -1, -1);
    check_val("lsb_4d", {5'd0, a_data}, 12'h04D);
    check_val("msb_59", {5'd0, b_data}, 12'h059);
    check_val("valid_up", {11'd0, a_valid}, 12'd1);
    tick();
    check_val("valid_one_cycle", {11'd0, a_valid}, 12'd0);

    // Overrun: consumer stalled across two completions.
    run_ab(7'h4D, 1'b1, 66, -1, 1'b0, -1, -1, -1);
    run_ab(7'h12, 1'b1, 66, -1, 1'b0, -1, -1, -1);
    check_val("ovr_hold_data", {5'd0, a_data}, 12'h04D);
    check_val("ovr_flag", {11'd0, a_ovr}, 12'd1);

    // Ready exactly on the second completion edge: reload, no overrun.
    run_ab(7'h00, 1'b0, 2, -1, 1'b0, -1, -1, 1);
    run_ab(7'h4D, 1'b1, 66, -1, 1'b0, -1, -1, -1);
    run_ab(7'h12, 1'b1, 66, 66, 1'b0, -1, -1, -1);
    check_val("simul_data", {5'd0, a_data}, 12'h012);
    check_val("simul_valid", {11'd0, a_valid}, 12'd1);
    check_val("simul_ovr", {11'd0, a_ovr}, 12'd0);

    // Starts mid-frame ignored, then back-to-back frames.
    run_ab(7'h4D, 1'b1, 66, -1, 1'b1, 20, 40, -1);
    check_val("ign_start", {5'd0, a_data}, 12'h04D);
    run_ab(7'h2A, 1'b1, 65, -1, 1'b1, -1, -1, -1);
    run_ab(7'h35, 1'b1, 66, -1, 1'b1, -1, -1, -1);
    check_val("b2b_data", {5'd0, a_data}, 12'h035);

    // Reset mid-frame, then a full frame of ones.
    run_ab(7'h4D, 1'b1, 30, -1, 1'b0, -1, -1, 30);
    check_val("midrst_busy", {11'd0, a_busy}, 12'd0);
    check_val("midrst_data", {5'd0, a_data}, 12'd0);
    run_ab(7'h7F, 1'b1, 66, -1, 1'b0, -1, -1, -1);
    check_val("ones", {5'd0, a_data}, 12'h07F);

    // Wide, fast configuration.
    pc = 12'hA5C;
    for (int e = 0; e <= 35; e++) begin
      c_start = (e == 0);
      b = (e - 1) / 3;
      c_din = (e >= 1 && b < 12) ? pc[b] : 1'($urandom_range(1, 0));
      c_rdy = 1'b0;
      ab_start = 1'b0; ab_din = 1'b0; ab_rdy = 1'b1;
      tick();
      if (e == 34) check_val("c_not_yet", {11'd0, c_valid}, 12'd0);
    end
    c_start = 1'b0;
    check_val("c_a5c", c_data, 12'hA5C);
    check_val("c_valid", {11'd0, c_valid}, 12'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      ab_rstn  = ($urandom_range(399, 0) != 0);
      c_rstn   = ($urandom_range(399, 0) != 0);
      ab_start = ($urandom_range(19, 0) == 0);
      c_start  = ($urandom_range(9, 0) == 0);
      ab_din   = 1'($urandom_range(1, 0));
      c_din    = 1'($urandom_range(1, 0));
      ab_rdy   = ($urandom_range(2, 0) != 0);
      c_rdy    = ($urandom_range(3, 0) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
